// File: rtl/egress_pkg.sv
// rtl/egress_pkg.sv - shared types and defaults for the FIFO stream egress block
package egress_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FRAME   = 2'd1,
    DISCARD = 2'd2
  } egress_state_t;

  localparam int DEF_DWIDTH    = 16;
  localparam int DEF_MAX_BEATS = 1024;
  localparam int DEF_BCWIDTH   = 11;

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - 2-entry skid buffer; in_ready depends only on registered state
module stream_skid_buf #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             xfer;

  assign xfer     = main_valid_q & m_ready;
  assign in_ready = ~skid_valid_q;
  assign m_valid  = main_valid_q;
  assign m_data   = main_data_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      // in_ready is low here, so no new word can arrive this cycle
      if (xfer) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_valid) begin
      if (~main_valid_q | xfer) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end else if (xfer) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/fifo_stream_egress.sv
// rtl/fifo_stream_egress.sv - look-ahead FIFO to valid/ready stream with frame truncation
// Optional frame/drop statistics counters enabled by EGRESS_STATS_EN.
module fifo_stream_egress
  import egress_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int MAX_BEATS = DEF_MAX_BEATS,
  parameter int BCWIDTH   = DEF_BCWIDTH
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               fifo_empty,
  input  logic [DWIDTH:0]    fifo_dout_comb,
  output logic               fifo_re,
  output logic [DWIDTH-1:0]  m_data,
  output logic               m_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [BCWIDTH-1:0] beat_cnt,
  output logic               err_oversize,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        drop_cnt
);

  typedef struct packed {
    logic              last;
    logic [DWIDTH-1:0] data;
  } egress_word_t;

  localparam logic [BCWIDTH-1:0] MAX_BC = BCWIDTH'(MAX_BEATS);

  egress_word_t       head_w, fwd_w, m_w;
  egress_state_t      state_q, state_d;
  logic [BCWIDTH-1:0] beat_cnt_q, beat_cnt_d, next_beat;
  logic               err_q, err_d;
  logic               skid_ready, pop, fwd_valid;

  assign head_w = fifo_dout_comb;

  // Discarded words never enter the buffer, so popping in DISCARD ignores back-pressure
  assign pop     = ~fifo_empty & ((state_q == DISCARD) | skid_ready);
  assign fifo_re = pop;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = 1'b0;
    fwd_valid  = 1'b0;
    fwd_w      = head_w;
    next_beat  = (state_q == IDLE) ? BCWIDTH'(1) : beat_cnt_q + 1'b1;
    if (pop) begin
      unique case (state_q)
        IDLE, FRAME: begin
          fwd_valid = 1'b1;
          if (head_w.last) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else if (next_beat == MAX_BC) begin
            fwd_w.last = 1'b1;
            err_d      = 1'b1;
            state_d    = DISCARD;
            beat_cnt_d = next_beat;
          end else begin
            state_d    = FRAME;
            beat_cnt_d = next_beat;
          end
        end
        DISCARD: begin
          if (head_w.last) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end
        end
        default: begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  stream_skid_buf #(
    .WIDTH(DWIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .arst_n   (arst_n),
    .in_valid (fwd_valid),
    .in_data  (fwd_w),
    .in_ready (skid_ready),
    .m_valid  (m_valid),
    .m_data   (m_w),
    .m_ready  (m_ready)
  );

  assign m_data       = m_w.data;
  assign m_last       = m_w.last;
  assign beat_cnt     = beat_cnt_q;
  assign err_oversize = err_q;

`ifdef EGRESS_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (m_valid & m_ready & m_w.last & (frame_cnt_q != 16'hFFFF)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (pop & (state_q == DISCARD) & (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_egress.sv
// tb/tb_fifo_stream_egress.sv - scoreboard bench for fifo_stream_egress (MAX_BEATS=4)
module tb_fifo_stream_egress;

  localparam int DW  = 16;
  localparam int MB  = 4;
  localparam int BCW = 3;
`ifdef EGRESS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           arst_n;
  logic           fifo_empty;
  logic [DW:0]    fifo_dout_comb;
  logic           fifo_re;
  logic [DW-1:0]  m_data;
  logic           m_last, m_valid, m_ready;
  logic [BCW-1:0] beat_cnt;
  logic           err_oversize;
  logic [15:0]    frame_cnt, drop_cnt;

  always #5 clk = ~clk;

  fifo_stream_egress #(
    .DWIDTH(DW), .MAX_BEATS(MB), .BCWIDTH(BCW)
  ) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .fifo_empty     (fifo_empty),
    .fifo_dout_comb (fifo_dout_comb),
    .fifo_re        (fifo_re),
    .m_data         (m_data),
    .m_last         (m_last),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .beat_cnt       (beat_cnt),
    .err_oversize   (err_oversize),
    .frame_cnt      (frame_cnt),
    .drop_cnt       (drop_cnt)
  );

  int          n_vec, n_err;
  logic [DW:0] fq[$];
  logic [DW:0] exp_q[$];
  int          bc_log[$];
  int          xfer_log[$];
  int          rdy_mode, gap_pct, cyc, pop_cnt, first_re, first_val;
  int          err_seen, exp_errs, exp_frames, exp_drops;
  bit          prev_stall, prev_re;
  logic [DW:0] prev_word;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_frame(input int len, input logic [DW-1:0] base, input bit rnd);
    int keep;
    keep = (len < MB) ? len : MB;
    for (int i = 0; i < len; i++) begin
      logic [DW-1:0] d;
      d = rnd ? DW'($urandom) : base + DW'(i);
      fq.push_back({(i == len - 1), d});
      if (i < keep) exp_q.push_back({(i == keep - 1), d});
    end
    exp_frames++;
    if (len > MB) begin
      exp_errs++;
      exp_drops += len - MB;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'b0;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    fifo_empty     = (fq.size() == 0) || (int'($urandom_range(0, 99)) < gap_pct);
    fifo_dout_comb = fifo_empty ? (DW+1)'($urandom) : fq[0];
    #1;
    cyc++;
    if (prev_re) bc_log.push_back(int'(beat_cnt));
    if (fifo_re) begin
      chk("re_while_empty", fifo_empty, 0);
      if (first_re < 0) first_re = cyc;
    end
    if (m_valid && first_val < 0) first_val = cyc;
    if (prev_stall) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_word", {m_last, m_data}, prev_word);
    end
    if (m_valid && m_ready) begin
      xfer_log.push_back(cyc);
      if (exp_q.size() == 0) chk("sb_underflow", m_valid, 0);
      else chk("beat", {m_last, m_data}, exp_q.pop_front());
    end
    if (err_oversize) err_seen++;
    prev_stall = m_valid & ~m_ready;
    prev_word  = {m_last, m_data};
    prev_re    = fifo_re;
    if (fifo_re) begin
      pop_cnt++;
      fq.delete(0);
    end
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0 || m_valid) && n < max_cyc) begin
      cycle();
      n++;
    end
    chk("drain_left", fq.size() + exp_q.size(), 0);
  endtask

  task automatic stats_check(input string tag);
    chk({tag, "_frame_cnt"}, frame_cnt, STATS ? exp_frames : 0);
    chk({tag, "_drop_cnt"}, drop_cnt, STATS ? exp_drops : 0);
    chk({tag, "_err_pulses"}, err_seen, exp_errs);
  endtask

  task automatic start_test();
    first_re  = -1;
    first_val = -1;
    pop_cnt   = 0;
    bc_log.delete();
    xfer_log.delete();
  endtask

  initial begin
    int n;
    n_vec = 0; n_err = 0; cyc = 0;
    err_seen = 0; exp_errs = 0; exp_frames = 0; exp_drops = 0;
    prev_stall = 1'b0; prev_re = 1'b0; prev_word = '0;
    rdy_mode = 0; gap_pct = 0;
    arst_n = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_dout_comb = '0;
    #2;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_word", {m_last, m_data}, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_err", err_oversize, 0);
    chk("rst_fifo_re", fifo_re, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    @(negedge clk);
    arst_n = 1'b1;

    // plain 4-beat frame, full throughput
    start_test();
    load_frame(4, 16'hA001, 1'b0);
    drain(50);
    chk("t1_latency", first_val - first_re, 1);
    chk("t1_xfers", xfer_log.size(), 4);
    if (xfer_log.size() == 4) chk("t1_back_to_back", xfer_log[3] - xfer_log[0], 3);
    chk("t1_bc_n", bc_log.size(), 4);
    for (int i = 0; i < 4 && i < bc_log.size(); i++) chk("t1_beat_cnt", bc_log[i], (i < 3) ? i + 1 : 0);

    // back-pressure: only two words may be absorbed while stalled
    start_test();
    load_frame(4, 16'hB001, 1'b0);
    rdy_mode = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (m_valid) chk("t2_stall_data", m_data, 16'hB001);
    end
    chk("t2_pops_stalled", pop_cnt, 2);
    rdy_mode = 0;
    drain(50);

    // oversize frame truncated, then a normal frame
    start_test();
    load_frame(7, 16'hC001, 1'b0);
    load_frame(2, 16'hC101, 1'b0);
    drain(100);
    stats_check("t3");

    // async reset mid-frame
    start_test();
    load_frame(5, 16'hD001, 1'b0);
    n = 0;
    while (beat_cnt != 3'd2 && n < 20) begin
      cycle();
      n++;
    end
    chk("t5_reach_beat2", beat_cnt, 2);
    arst_n = 1'b0;
    #1;
    chk("t5_rst_valid", m_valid, 0);
    chk("t5_rst_beat_cnt", beat_cnt, 0);
    chk("t5_rst_frame_cnt", frame_cnt, 0);
    fq.delete();
    exp_q.delete();
    prev_stall = 1'b0; prev_re = 1'b0;
    err_seen = 0; exp_errs = 0; exp_frames = 0; exp_drops = 0;
    repeat (2) cycle();
    arst_n = 1'b1;
    chk("t5_post_beat_cnt", beat_cnt, 0);
    load_frame(3, 16'hE001, 1'b0);
    drain(50);
    stats_check("t5");

    // random back-pressure and FIFO gaps
    start_test();
    rdy_mode = 2;
    gap_pct  = 30;
    for (int f = 0; f < 1000; f++) load_frame(int'($urandom_range(1, 8)), '0, 1'b1);
    drain(60000);
    stats_check("t4");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
